// File: rtl/nco_ctrl_pkg.sv
// rtl/nco_ctrl_pkg.sv - shared types and defaults for the NCO update controller
package nco_ctrl_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] step;
    logic [WIDTH_DEF-1:0] phase;
    logic                 sync;
  } shadow_t;

endpackage

// File: rtl/nco_ctrl_shadow_reg.sv
// rtl/nco_ctrl_shadow_reg.sv - load/clear shadow register holding the pending update
module nco_ctrl_shadow_reg
  import nco_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_step,
  input  logic [WIDTH-1:0] in_phase,
  input  logic             in_sync,
  output logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] phase,
  output logic             sync
);

  // Capture a request on accept; a cancel or reset discards it.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      step  <= '0;
      phase <= '0;
      sync  <= 1'b0;
    end else if (load) begin
      step  <= in_step;
      phase <= in_phase;
      sync  <= in_sync;
    end
  end

endmodule

// File: rtl/nco_update_ctrl.sv
// rtl/nco_update_ctrl.sv - epoch-synchronous NCO step/phase update controller (option: NCO_CTRL_IMMEDIATE_EN)
module nco_update_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             epoch,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_step,
  input  logic [WIDTH-1:0] req_phase,
  input  logic             req_sync,
`ifdef NCO_CTRL_IMMEDIATE_EN
  input  logic             req_immediate,
`endif
  input  logic             cancel,
  output logic             nco_enable,
  output logic             nco_phase_sync,
  output logic [WIDTH-1:0] nco_phase_in,
  output logic [WIDTH-1:0] nco_step,
  output logic             pending,
  output logic             applied,
  output logic [CNT_W-1:0] applied_cnt
);

  state_t           state_q, state_d;
  logic             accept;
  logic             imm;
  logic             shadow_load;
  logic             shadow_clear;
  logic             apply_req;
  logic             apply_shadow;
  logic [WIDTH-1:0] sh_step;
  logic [WIDTH-1:0] sh_phase;
  logic             sh_sync;
  logic [CNT_W-1:0] cnt_q;

`ifdef NCO_CTRL_IMMEDIATE_EN
  assign imm = req_immediate;
`else
  assign imm = 1'b0;
`endif

  assign req_ready   = (state_q == ST_IDLE) && !reset;
  assign accept      = req_valid && req_ready;
  assign pending     = (state_q == ST_ARMED);
  assign applied_cnt = cnt_q;

  nco_ctrl_shadow_reg #(.WIDTH(WIDTH)) u_shadow (
    .clk      (clk),
    .reset    (reset),
    .load     (shadow_load),
    .clear    (shadow_clear),
    .in_step  (req_step),
    .in_phase (req_phase),
    .in_sync  (req_sync),
    .step     (sh_step),
    .phase    (sh_phase),
    .sync     (sh_sync)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and the strobes that steer shadow and output loads.
  always_comb begin
    state_d      = state_q;
    shadow_load  = 1'b0;
    shadow_clear = 1'b0;
    apply_req    = 1'b0;
    apply_shadow = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Any epoch seen here is ignored; the request waits for a later one.
        if (accept) begin
          shadow_load = 1'b1;
          if (imm) begin
            apply_req = 1'b1;
            state_d   = ST_APPLY;
          end else begin
            state_d   = ST_ARMED;
          end
        end
      end
      ST_ARMED: begin
        // Cancel beats a coincident epoch.
        if (cancel) begin
          shadow_clear = 1'b1;
          state_d      = ST_IDLE;
        end else if (epoch) begin
          apply_shadow = 1'b1;
          state_d      = ST_APPLY;
        end
      end
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NCO-facing registers load on entry to APPLY so they are valid during it.
  always_ff @(posedge clk) begin
    if (reset) begin
      nco_enable     <= 1'b0;
      nco_phase_sync <= 1'b0;
      nco_phase_in   <= '0;
      nco_step       <= '0;
      applied        <= 1'b0;
    end else begin
      nco_enable     <= run;
      applied        <= apply_req || apply_shadow;
      nco_phase_sync <= (apply_shadow && sh_sync) || (apply_req && req_sync);
      if (apply_shadow) begin
        nco_step     <= sh_step;
        nco_phase_in <= sh_phase;
      end else if (apply_req) begin
        nco_step     <= req_step;
        nco_phase_in <= req_phase;
      end
    end
  end

  // Applied-update counter, wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (reset)                          cnt_q <= '0;
    else if (apply_req || apply_shadow) cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: doc/nco_update_ctrl.md
# nco_update_ctrl

Epoch-synchronous update controller for the carrier/code NCO phase accumulator. It accepts step (frequency) and phase updates from the tracking-loop firmware over a valid/ready handshake and holds them pending. It applies each update to the NCO on the next epoch boundary, so loop updates never land mid-integration. It sits between the channel register bank and one NCO instance and drives that NCO's enable, phase_sync, phase_in and step inputs.

## Interface
- WIDTH, 32, width of step and phase words; matches the NCO accumulator width.
- CNT_W, 16, width of the applied-update counter.

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- run  in  1  firmware run enable for the NCO
- epoch  in  1  single-cycle pulse marking an update boundary (code epoch)
- req_valid  in  1  update request valid
- req_ready  out  1  controller can accept a request
- req_step  in  WIDTH  new phase step
- req_phase  in  WIDTH  phase to load when req_sync=1
- req_sync  in  1  also realign the accumulator to req_phase
- req_immediate  in  1  apply without waiting for epoch (only present with NCO_CTRL_IMMEDIATE_EN)
- cancel  in  1  discard the pending request
- nco_enable  out  1  to NCO enable
- nco_phase_sync  out  1  to NCO phase_sync
- nco_phase_in  out  WIDTH  to NCO phase_in
- nco_step  out  WIDTH  to NCO step
- pending  out  1  a request is armed and waiting for an epoch
- applied  out  1  single-cycle pulse, update took effect
- applied_cnt  out  CNT_W  count of applied updates

## Operation
- States: IDLE, ARMED, APPLY.
- IDLE: req_ready=1. On req_valid&req_ready, latch step, phase and sync into the shadow register and go to ARMED. If immediate mode is enabled and req_immediate=1, go to APPLY instead.
- ARMED: req_ready=0, pending=1.
  - cancel → IDLE. The shadow is discarded and the outputs are unchanged.
  - epoch → APPLY.
  - cancel and epoch in the same cycle: cancel wins.
- APPLY (exactly one cycle):
  - nco_step ← shadow step.
  - nco_phase_in ← shadow phase.
  - nco_phase_sync=1 iff the shadow sync flag is set.
  - applied=1.
  - applied_cnt increments, wrapping 2^CNT_W-1 → 0.
  - epoch and cancel are ignored.
  - Next state is IDLE.
- nco_step and nco_phase_in are registers. They hold their value between updates and change only on entry to APPLY.
- nco_enable is a registered copy of run. run does not affect the FSM; pending updates survive run=0.
- An epoch in IDLE, or in the cycle a request is accepted, is not used. A request always waits for a later epoch.

## Timing
- Reset values (the cycle after reset is sampled high):
  - state IDLE.
  - nco_step=0, nco_phase_in=0, nco_phase_sync=0, nco_enable=0.
  - applied=0, applied_cnt=0, pending=0.
  - req_ready=0 while reset is high, then 1.
- Reset mid-operation drops any pending request. Reset takes priority over all inputs.
- Accept at cycle T (valid&ready) → pending=1 at T+1.
- Epoch sampled at cycle E while ARMED → nco_step/nco_phase_in/nco_phase_sync/applied valid during E+1. The NCO sees the new step from E+2. req_ready=1 again at E+2.
- Immediate accept at T → APPLY outputs during T+1, ready at T+2.
- Minimum request spacing is 3 cycles (accept, ARMED, APPLY).
- run → nco_enable latency is 1 cycle.

## Configuration
- NCO_CTRL_IMMEDIATE_EN defined: the req_immediate port exists. A request accepted with req_immediate=1 bypasses ARMED (IDLE→APPLY) and never asserts pending.
- NCO_CTRL_IMMEDIATE_EN undefined: no req_immediate port, and every request waits for an epoch.

## Structure
- Shared package nco_ctrl_pkg holds:
  - the state enum (IDLE, ARMED, APPLY);
  - default WIDTH=32 and CNT_W=16 constants;
  - the shadow-record typedef (step, phase, sync).
- One sub-module, nco_ctrl_shadow_reg: the load/clear shadow register holding the pending request. The FSM, output registers and counter live in the top.

## Test plan
- Reset, then request step=0x0000_1000, sync=0, with epoch at T+5 → applied pulse and nco_step=0x1000 in cycle T+6; nco_phase_sync stays 0; applied_cnt=1.
- Request step=0x10, phase=0x8000_0000, sync=1 → nco_phase_sync=1 for exactly one cycle with nco_phase_in=0x8000_0000; NCO accumulator reads 0x8000_0000 afterwards.
- Epoch coincident with request acceptance → no apply; apply occurs only on the following epoch.
- cancel and epoch in the same ARMED cycle → IDLE, applied stays 0, nco_step unchanged, ready next cycle.
- Preset applied_cnt to 0xFFFF via 65535 updates (or force) → next apply wraps it to 0x0000. Reset asserted while ARMED → pending=0 and outputs return to 0.
- With NCO_CTRL_IMMEDIATE_EN, req_immediate=1 accepted at T → applied in T+1 with no epoch; pending never asserts.
